// File: rtl/chirp_nco_pkg.sv
// Shared encodings for the chirp NCO sequencer: sweep modes and FSM states.
package chirp_nco_pkg;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    localparam logic [1:0] MODE_CW   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_DOWN = 3'd2,
        ST_HOLD = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // First run state of a sweep; triangle starts on its rising half.
    function automatic state_t first_run_state(input logic [1:0] mode);
        case (mode)
            MODE_DOWN: first_run_state = ST_DOWN;
            MODE_CW:   first_run_state = ST_HOLD;
            default:   first_run_state = ST_UP;
        endcase
    endfunction

endpackage

// File: rtl/chirp_nco_seq_fold.sv
// Octant fold of a phase word into a quarter-wave LUT address plus sign/swap bits.
module nco_octant_fold #(
    parameter int PW = 24,
    parameter int WA = 8
) (
    input  logic [PW-1:0] phase,
    output logic [WA-1:0] addr,
    output logic          re_sig,
    output logic          im_sig,
    output logic          sel
);

    logic [2:0]    a0_s;
    logic [WA-1:0] a1_s;

    // Odd octants run the quarter wave backwards, hence the address mirror.
    always_comb begin
        a0_s   = phase[PW-1 -: 3];
        a1_s   = phase[PW-4 -: WA];
        addr   = a0_s[0] ? ~a1_s : a1_s;
        re_sig = a0_s[2] ^ a0_s[1];
        im_sig = a0_s[2];
        sel    = a0_s[1] ^ a0_s[0];
    end

endmodule

// File: rtl/chirp_nco_seq.sv
// Chirp sequencer: sweeps phase/frequency per mode and emits folded LUT addresses.
module chirp_nco_seq
    import chirp_nco_pkg::*;
#(
    parameter int PW = 24,
    parameter int WA = 8,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] f_start,
    input  logic [PW-1:0] f_step,
    input  logic [LW-1:0] n_samples,
    output logic          busy,
    output logic          valid,
    output logic          done,
    output logic [WA-1:0] addr,
    output logic          re_sig,
    output logic          im_sig,
    output logic          sel,
    output logic [PW-1:0] freq
);

    state_t        state_r, state_nxt_s;
    logic [1:0]    mode_r;
    logic [PW-1:0] f_step_r;
    logic [LW-1:0] n_r;
    logic [LW-1:0] half_r;
    logic [PW-1:0] phase_r;
    logic [PW-1:0] freq_r;
    logic [LW-1:0] cnt_r;
    logic          run_s;
    logic          last_s;
    logic          accept_s;
    logic [WA-1:0] addr_s;
    logic          re_s;
    logic          im_s;
    logic          sel_s;

    assign run_s    = (state_r == ST_UP) || (state_r == ST_DOWN) || (state_r == ST_HOLD);
    assign last_s   = (cnt_r == (n_r - LW'(1)));
    assign accept_s = (state_r == ST_IDLE) && start;

    // Next-state logic; abort outranks the last-sample exit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (n_samples == '0) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = first_run_state(mode);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UP, ST_DOWN, ST_HOLD: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_FIN;
                end else if ((state_r == ST_UP) && (mode_r == MODE_TRI)
                             && (cnt_r == (half_r - LW'(1)))) begin
                    state_nxt_s = ST_DOWN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, configuration latch and phase/frequency accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            mode_r   <= MODE_UP;
            f_step_r <= '0;
            n_r      <= '0;
            half_r   <= '0;
            phase_r  <= '0;
            freq_r   <= '0;
            cnt_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                mode_r   <= mode;
                f_step_r <= f_step;
                n_r      <= n_samples;
                half_r   <= n_samples >> 1;
                phase_r  <= '0;
                freq_r   <= f_start;
                cnt_r    <= '0;
            end else if (run_s) begin
                phase_r <= phase_r + freq_r;
                cnt_r   <= cnt_r + LW'(1);
                case (state_r)
                    ST_UP:   freq_r <= freq_r + f_step_r;
                    ST_DOWN: freq_r <= freq_r - f_step_r;
                    default: freq_r <= freq_r;
                endcase
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    nco_octant_fold #(.PW(PW), .WA(WA)) u_fold (
        .phase  (phase_r),
        .addr   (addr_s),
        .re_sig (re_s),
        .im_sig (im_s),
        .sel    (sel_s)
    );

    // Output decode from registered state; sample fields are zero outside valid.
    always_comb begin
        busy   = (state_r != ST_IDLE);
        valid  = run_s;
        done   = (state_r == ST_FIN);
        if (run_s) begin
            addr   = addr_s;
            re_sig = re_s;
            im_sig = im_s;
            sel    = sel_s;
            freq   = freq_r;
        end else begin
            addr   = '0;
            re_sig = 1'b0;
            im_sig = 1'b0;
            sel    = 1'b0;
            freq   = '0;
        end
    end

endmodule

// File: tb/tb_chirp_nco_seq.sv
// Directed self-checking bench for chirp_nco_seq at PW=12, WA=4, LW=8.
module tb_chirp_nco_seq;

    localparam int PW = 12;
    localparam int WA = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_step;
    logic [LW-1:0] n_samples;
    logic          busy, valid, done, re_sig, im_sig, sel;
    logic [WA-1:0] addr;
    logic [PW-1:0] freq;

    int checks_total  = 0;
    int checks_passed = 0;

    chirp_nco_seq #(.PW(PW), .WA(WA), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .f_start   (f_start),
        .f_step    (f_step),
        .n_samples (n_samples),
        .busy      (busy),
        .valid     (valid),
        .done      (done),
        .addr      (addr),
        .re_sig    (re_sig),
        .im_sig    (im_sig),
        .sel       (sel),
        .freq      (freq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Called at a negedge; start is seen at the following posedge.
    task automatic launch(input logic [1:0] m, input int fs, input int fst, input int n);
        mode      = m;
        f_start   = PW'(fs);
        f_step    = PW'(fst);
        n_samples = LW'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic check_sample(input string tag, input int ea, input int er, input int ei,
                                input int es, input int ef);
        check({tag, ".valid"}, 32'(valid), 32'd1);
        check({tag, ".busy"},  32'(busy),  32'd1);
        check({tag, ".addr"},  32'(addr),  32'(ea));
        check({tag, ".re"},    32'(re_sig), 32'(er));
        check({tag, ".im"},    32'(im_sig), 32'(ei));
        check({tag, ".sel"},   32'(sel),   32'(es));
        check({tag, ".freq"},  32'(freq),  32'(ef));
        @(negedge clk);
    endtask

    task automatic check_done(input string tag);
        check({tag, ".done"},       32'(done),  32'd1);
        check({tag, ".done_busy"},  32'(busy),  32'd1);
        check({tag, ".done_valid"}, 32'(valid), 32'd0);
        @(negedge clk);
        check({tag, ".idle_done"},  32'(done),  32'd0);
        check({tag, ".idle_busy"},  32'(busy),  32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"},  32'(busy),  32'd0);
        check({tag, ".valid"}, 32'(valid), 32'd0);
        check({tag, ".done"},  32'(done),  32'd0);
        check({tag, ".addr"},  32'(addr),  32'd0);
        check({tag, ".sigs"},  32'({re_sig, im_sig, sel}), 32'd0);
        check({tag, ".freq"},  32'(freq),  32'd0);
    endtask

    initial begin
        int oa[8];
        int ore[8];
        int oim[8];
        int osel[8];
        int tf[6];
        int seen_done;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 2'd0; f_start = '0; f_step = '0; n_samples = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        @(negedge clk);

        // CW: one address step per sample
        launch(2'd3, 32, 0, 4);
        for (int i = 0; i < 4; i++) check_sample($sformatf("cw%0d", i), i, 0, 0, 0, 32);
        check_done("cw");

        // Up-ramp: phase 0,0,32,96
        launch(2'd0, 0, 32, 4);
        check_sample("up0", 0, 0, 0, 0, 0);
        check_sample("up1", 0, 0, 0, 0, 32);
        check_sample("up2", 1, 0, 0, 0, 64);
        check_sample("up3", 3, 0, 0, 0, 96);
        check_done("up");

        // Octant walk
        oa   = '{0, 15, 0, 15, 0, 15, 0, 15};
        ore  = '{0, 0, 1, 1, 1, 1, 0, 0};
        oim  = '{0, 0, 0, 0, 1, 1, 1, 1};
        osel = '{0, 1, 1, 0, 0, 1, 1, 0};
        launch(2'd3, 512, 0, 8);
        for (int i = 0; i < 8; i++)
            check_sample($sformatf("oct%0d", i), oa[i], ore[i], oim[i], osel[i], 512);
        check_done("oct");

        // Triangle n=6, phase stays below one address step
        tf = '{0, 1, 2, 3, 2, 1};
        launch(2'd2, 0, 1, 6);
        for (int i = 0; i < 6; i++) check_sample($sformatf("tri%0d", i), 0, 0, 0, 0, tf[i]);
        check_done("tri");

        // Down-ramp wraps modulo 2^12
        launch(2'd1, 0, 1, 2);
        check_sample("dn0", 0, 0, 0, 0, 0);
        check_sample("dn1", 0, 0, 0, 0, 4095);
        check_done("dn");

        // n=0: straight to done
        launch(2'd0, 100, 1, 0);
        check_done("n0");

        // Start mid-chirp with new config is ignored
        launch(2'd3, 32, 0, 4);
        check_sample("ign0", 0, 0, 0, 0, 32);
        start = 1'b1; mode = 2'd0; f_start = 12'd512; n_samples = 8'd1;
        check_sample("ign1", 1, 0, 0, 0, 32);
        start = 1'b0;
        check_sample("ign2", 2, 0, 0, 0, 32);
        check_sample("ign3", 3, 0, 0, 0, 32);
        check_done("ign");

        // Abort during sample 2
        launch(2'd3, 32, 0, 8);
        check_sample("ab0", 0, 0, 0, 0, 32);
        check_sample("ab1", 1, 0, 0, 0, 32);
        abort = 1'b1;
        check_sample("ab2", 2, 0, 0, 0, 32);
        abort = 1'b0;
        check_quiet("ab_after");
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done = 1;
            @(negedge clk);
        end
        check("ab_no_done", 32'(seen_done), 32'd0);

        // Reset during sample 3
        launch(2'd3, 512, 0, 8);
        check_sample("rs0", 0, 0, 0, 0, 512);
        check_sample("rs1", 15, 0, 0, 1, 512);
        check_sample("rs2", 0, 1, 0, 1, 512);
        reset = 1'b1;
        check("rs3.valid", 32'(valid), 32'd1);
        @(negedge clk);
        check_quiet("rs_after");
        reset = 1'b0;
        @(negedge clk);
        check_quiet("rs_idle");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
